// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (DIFF = A - B), LSB first, one bit per clock.
// A single full-subtractor cell with a registered borrow; start/done handshake.
module serial_fs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bff_q, borrow_q;

  logic             d_bit, bout_bit;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  serial_fs_cell u_cell (
    .a_i   (opa_q[0]),
    .b_i   (opb_q[0]),
    .bin_i (bff_q),
    .d_o   (d_bit),
    .bout_o(bout_bit)
  );

  assign res_d    = {d_bit, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      bff_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= A;
            opb_q   <= B;
            bff_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q <= res_d;
          opa_q <= {1'b0, opa_q[WIDTH-1:1]};
          opb_q <= {1'b0, opb_q[WIDTH-1:1]};
          bff_q <= bout_bit;
          // Results are published only on the final bit, so DIFF never shows a partial word.
          if (last_bit) begin
            diff_q   <= res_d;
            borrow_q <= bout_bit;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign DIFF   = diff_q;
  assign BORROW = borrow_q;
endmodule
